// File: rtl/route_cntrl.sv
// route_cntrl: multi-stop route controller. It keeps a FIFO of barcode
// destination IDs and drives the robot to each stop in turn. At every
// intermediate stop it waits a fixed dwell time before moving on. While the
// robot should be moving but the path is blocked, it sounds a piezo buzzer.
module route_cntrl #(
  parameter int ID_W      = 6,
  parameter int DEPTH     = 4,
  parameter int DWELL_CYC = 50000000,
  parameter int BUZZ_HALF = 6250
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [ID_W+1:0]              cmd,
  input  logic                         cmd_rdy,
  output logic                         clr_cmd_rdy,
  input  logic [ID_W-1:0]              ID,
  input  logic                         ID_vld,
  output logic                         clr_ID_vld,
  input  logic                         OK2Move,
  output logic                         in_transit,
  output logic                         go,
  output logic                         buzz,
  output logic                         buzz_n,
  output logic [$clog2(DEPTH+1)-1:0]   q_cnt,
  output logic                         q_full,
  output logic                         ovf
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);
  localparam int DW = (DWELL_CYC > 1) ? $clog2(DWELL_CYC+1) : 1;
  localparam int BW = $clog2(BUZZ_HALF);

  localparam logic [PW-1:0] P_LAST     = PW'(DEPTH-1);
  localparam logic [CW-1:0] C_DEPTH    = CW'(DEPTH);
  localparam logic [CW-1:0] C_ONE      = CW'(1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYC-1);
  localparam logic [BW-1:0] BUZZ_LAST  = BW'(BUZZ_HALF-1);

  localparam logic [1:0] OP_STOP = 2'b00;
  localparam logic [1:0] OP_GO   = 2'b01;
  localparam logic [1:0] OP_APND = 2'b10;
  localparam logic [1:0] OP_SKIP = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_TRANSIT, S_DWELL} state_t;

  state_t            r_state, w_nxt;
  logic [ID_W-1:0]   r_mem [DEPTH];
  logic [PW-1:0]     r_rd_ptr, r_wr_ptr;
  logic [CW-1:0]     r_cnt;
  logic              r_full;
  logic              r_in_transit;
  logic              r_ovf;
  logic [DW-1:0]     r_dwell;
  logic [BW-1:0]     r_bcnt;
  logic              r_buzz;

  logic [1:0]        w_op;
  logic [ID_W-1:0]   w_cmd_id;
  logic [ID_W-1:0]   w_head;
  logic              w_empty;
  logic              w_hit;
  logic              w_dwell_done;
  logic              w_buzz_en;
  logic              w_push, w_pop, w_flush, w_load, w_ovf;

  assign w_op         = cmd[ID_W+1:ID_W];
  assign w_cmd_id     = cmd[ID_W-1:0];
  assign w_head       = r_mem[r_rd_ptr];
  assign w_empty      = (r_cnt == '0);
  // A barcode counts only in transit and only when no command competes for the cycle.
  assign w_hit        = (r_state == S_TRANSIT) & ID_vld & ~cmd_rdy & ~w_empty & (ID == w_head);
  assign w_dwell_done = (r_state == S_DWELL) & ~cmd_rdy & (r_dwell >= DWELL_LAST);
  assign w_buzz_en    = r_in_transit & ~OK2Move;

  function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
    return (p == P_LAST) ? '0 : p + PW'(1);
  endfunction

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_nxt;
  end

  // Next-state decision: a command always overrides barcode and dwell events
  always_comb begin
    w_nxt = r_state;
    if (cmd_rdy) begin
      case (w_op)
        OP_STOP: w_nxt = S_IDLE;
        OP_GO:   w_nxt = S_TRANSIT;
        OP_APND: if (!r_full && r_state == S_IDLE && w_empty) w_nxt = S_TRANSIT;
        default: if (!w_empty) w_nxt = (r_cnt == C_ONE) ? S_IDLE : S_TRANSIT;
      endcase
    end else begin
      case (r_state)
        S_TRANSIT: if (w_hit) w_nxt = (r_cnt > C_ONE) ? S_DWELL : S_IDLE;
        S_DWELL:   if (w_dwell_done) w_nxt = S_TRANSIT;
        default:   w_nxt = r_state;
      endcase
    end
  end

  // Handshake pulses and FIFO controls; nothing is consumed while in reset
  always_comb begin
    clr_cmd_rdy = cmd_rdy & ~rst;
    clr_ID_vld  = ID_vld & ~cmd_rdy & ~rst;
    w_flush     = cmd_rdy & (w_op == OP_STOP || w_op == OP_GO);
    w_load      = cmd_rdy & (w_op == OP_GO);
    w_push      = cmd_rdy & (w_op == OP_APND) & ~r_full;
    w_ovf       = cmd_rdy & (w_op == OP_APND) & r_full;
    w_pop       = (cmd_rdy & (w_op == OP_SKIP) & ~w_empty) | w_hit;
  end

  // Route FIFO. Push and pop are never active together because commands take priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_cnt    <= '0;
      r_full   <= 1'b0;
    end else if (w_load) begin
      r_mem[r_wr_ptr] <= w_cmd_id;
      r_rd_ptr        <= r_wr_ptr;
      r_wr_ptr        <= f_inc(r_wr_ptr);
      r_cnt           <= C_ONE;
      r_full          <= (C_ONE == C_DEPTH);
    end else if (w_flush) begin
      r_rd_ptr <= r_wr_ptr;
      r_cnt    <= '0;
      r_full   <= 1'b0;
    end else if (w_push) begin
      r_mem[r_wr_ptr] <= w_cmd_id;
      r_wr_ptr        <= f_inc(r_wr_ptr);
      r_cnt           <= r_cnt + C_ONE;
      r_full          <= ((r_cnt + C_ONE) == C_DEPTH);
    end else if (w_pop) begin
      r_rd_ptr <= f_inc(r_rd_ptr);
      r_cnt    <= r_cnt - C_ONE;
      r_full   <= 1'b0;
    end
  end

  // Dwell timer. It restarts on entry, keeps counting through APPENDs and saturates at the limit.
  always_ff @(posedge clk) begin
    if (rst)                                          r_dwell <= '0;
    else if (r_state == S_DWELL && w_nxt == S_DWELL)  r_dwell <= (r_dwell >= DWELL_LAST) ? r_dwell : r_dwell + DW'(1);
    else                                              r_dwell <= '0;
  end

  // Registered status: motion request and overflow pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      r_in_transit <= 1'b0;
      r_ovf        <= 1'b0;
    end else begin
      r_in_transit <= (w_nxt == S_TRANSIT);
      r_ovf        <= w_ovf;
    end
  end

  // Buzzer square wave. It is held low and re-phased whenever it is disabled.
  always_ff @(posedge clk) begin
    if (rst || !w_buzz_en) begin
      r_bcnt <= '0;
      r_buzz <= 1'b0;
    end else if (r_bcnt == BUZZ_LAST) begin
      r_bcnt <= '0;
      r_buzz <= ~r_buzz;
    end else begin
      r_bcnt <= r_bcnt + BW'(1);
    end
  end

  assign in_transit = r_in_transit;
  assign go         = r_in_transit & OK2Move;
  assign buzz       = r_buzz;
  assign buzz_n     = ~r_buzz;
  assign q_cnt      = r_cnt;
  assign q_full     = r_full;
  assign ovf        = r_ovf;

endmodule
